fuzzy_1_core: RTL and testbench
===============================

Name: fuzzy_1_core

Overview:
- Interval type-2 fuzzy controller with two 8-bit crisp inputs and one 8-bit defuzzified output.
- Each input is fuzzified into 3 FOUs (upper/lower membership). A 3x3 rule base is evaluated one rule row per cycle.
- Output is produced by Nie-Tan type reduction and defuzzification.
- Sits between the sensor-sampling logic and the actuator command path; runs free, frame after frame, while enabled.

Parameters:
- W_IN, 8, input/membership width (fixed at 8; other values unsupported).
- C0..C4, 16/72/128/184/240, consequent singleton values indexed by k = i+j.

Ports:
- clk_0  in  1  system clock; all logic on rising edge.
- Srst  in  1  synchronous, active-high reset.
- Entrada_01  in  8  crisp input 1 (meaningful range 1..254).
- Entrada_02  in  8  crisp input 2 (meaningful range 1..254).
- EN_REGRAS  in  1  rule-engine enable.
- FOU_ATIVO  out  6  active-FOU flags. Bits [2:0] = input 1 L/M/H; bits [5:3] = input 2 L/M/H.
- saida_defuzzy  out  8  defuzzified output.

Behaviour:
- Single clock, clk_0. No second clock exists in this block.
- Srst=1 at an edge:
  - state := SAMPLE.
  - Accumulators := 0.
  - saida_defuzzy := 0.
  - FOU_ATIVO := 0.
  - Reset mid-frame aborts the frame; no output update occurs.
- Upper MFs, for x in 0..255, saturated to 0..255:
  - L = x<128 ? 255-2x : 0.
  - M = x<128 ? 2x : 2(255-x), clipped to 255.
  - H = x>127 ? 2x-255 : 0.
- Lower MF = U - (U>>2), i.e. 3/4 scaled height with the same support.
- Frame FSM, 5 cycles:
  - SAMPLE: register both inputs; compute all 12 memberships into registers; FOU_ATIVO[k] := (upper_k != 0); clear accumulators.
  - ROW0, ROW1, ROW2: in ROWi, fire rules (i, j) for j=0..2, where i indexes the input-1 set (L,M,H) and j indexes the input-2 set.
    - Firing: up = min(U1_i, U2_j); lo = min(L1_i, L2_j); w = up+lo (9 bits).
    - Accumulate den += w and num += C[i+j]*w.
    - Widths: num 21 bits, den 13 bits, no overflow possible.
  - DEFUZ: saida_defuzzy := floor(num/den), via a combinational divider. If den==0, output 128. Result is always ≤240. Return to SAMPLE.
- EN_REGRAS=0: FSM stays in SAMPLE. Memberships are not updated and both outputs hold.
  - Deasserting EN_REGRAS mid-frame lets the current frame complete, then the FSM idles.
  - Reassertion starts a new frame on the next edge.
- Latency: an input change is reflected on saida_defuzzy within 9 cycles worst case (≤4 cycles to the next SAMPLE, plus 5).
- FOU_ATIVO updates at SAMPLE; saida_defuzzy updates at the DEFUZ edge only.
- Inputs 0 and 255 are processed arithmetically like any other value; no clamping inside the block.

Decomposition:
- Shared package contents:
  - Consequent constants C0..C4.
  - FSM state enum (SAMPLE, ROW0, ROW1, ROW2, DEFUZ).
  - Membership width and accumulator width constants.
- One sub-module, fuzzy_1_mf: a combinational fuzzifier taking one 8-bit input and producing 3 upper plus 3 lower memberships. It is instantiated twice.

Test Plan:
- Srst held, then released; EN_REGRAS=1, inputs (1,1) → saida_defuzzy=17 within 9 cycles; FOU_ATIVO=6'b011011.
- Inputs (254,254) → saida_defuzzy=238; FOU_ATIVO=6'b110110.
- Inputs (128,128) → saida_defuzzy=128; FOU_ATIVO=6'b110110.
- Inputs (1,254) → saida_defuzzy=128 (num 58240 / den 455); FOU_ATIVO=6'b110011.
- Sweep 1..254 on both inputs, changing every 14 cycles → output monotonic non-decreasing along each axis, and every sample settles before the next change.
- EN_REGRAS=0 mid-run with input change → outputs hold. Srst asserted during ROW1 → next edge gives saida_defuzzy=0 and FOU_ATIVO=0, and no stale update follows.

Source files
------------

// File: rtl/fuzzy_1_pkg.sv
// Purpose : shared constants, types and helpers for the interval type-2 fuzzy controller.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package fuzzy_1_pkg;

    localparam int W_IN  = 8;   // crisp input / membership grade width
    localparam int W_W   = 9;   // rule firing weight: upper + lower grade
    localparam int W_NUM = 21;  // numerator accumulator: 240 * 9 * 510 fits
    localparam int W_DEN = 13;  // denominator accumulator: 9 * 510 fits

    // Consequent singletons, indexed by k = i + j.
    localparam logic [W_IN-1:0] C0 = 8'd16;
    localparam logic [W_IN-1:0] C1 = 8'd72;
    localparam logic [W_IN-1:0] C2 = 8'd128;
    localparam logic [W_IN-1:0] C3 = 8'd184;
    localparam logic [W_IN-1:0] C4 = 8'd240;

    typedef enum logic [2:0] {SAMPLE, ROW0, ROW1, ROW2, DEFUZ} state_t;

    // Index 0 = L, 1 = M, 2 = H.
    typedef struct packed {
        logic [2:0][W_IN-1:0] up;
        logic [2:0][W_IN-1:0] lo;
    } mf_t;

    function automatic logic [W_IN-1:0] cons_at(input logic [2:0] k);
        case (k)
            3'd0:    return C0;
            3'd1:    return C1;
            3'd2:    return C2;
            3'd3:    return C3;
            default: return C4;
        endcase
    endfunction

    function automatic logic [W_IN-1:0] min8(input logic [W_IN-1:0] a, input logic [W_IN-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/fuzzy_1_if.sv
// Purpose : crisp inputs, enable and controller outputs bundled as one bus.
// Latency : n/a (wiring only).
// Backpressure: none; master drives inputs/enable, slave (core) drives FOU flags and output.
interface fuzzy_1_if;
    import fuzzy_1_pkg::*;

    logic [W_IN-1:0] Entrada_01;
    logic [W_IN-1:0] Entrada_02;
    logic            EN_REGRAS;
    logic [5:0]      FOU_ATIVO;
    logic [W_IN-1:0] saida_defuzzy;

    modport master (output Entrada_01, Entrada_02, EN_REGRAS, input FOU_ATIVO, saida_defuzzy);
    modport slave  (input Entrada_01, Entrada_02, EN_REGRAS, output FOU_ATIVO, saida_defuzzy);

endinterface

// File: rtl/fuzzy_1_mf.sv
// Purpose : combinational fuzzifier, one crisp input -> 3 upper + 3 lower memberships (L/M/H).
// Latency : 0 cycles (pure combinational).
// Backpressure: none.
// Ports   : x_i crisp input; mf_o upper/lower grades, index 0=L, 1=M, 2=H.
module fuzzy_1_mf
    import fuzzy_1_pkg::*;
(
    input  logic [W_IN-1:0] x_i,
    output mf_t             mf_o
);

    logic [6:0] fold;

    // All three upper MFs reduce to bit manipulation of x:
    //   x<128 : 255-2x = {~x[6:0],1},  2x = {x[6:0],0}
    //   x>=128: 2x-255 = {x[6:0],1},   2(255-x) = {~x[6:0],0}  (never exceeds 254)
    always_comb begin
        fold = x_i[7] ? ~x_i[6:0] : x_i[6:0];
        mf_o.up[0] = x_i[7] ? 8'd0 : {~x_i[6:0], 1'b1};
        mf_o.up[1] = {fold, 1'b0};
        mf_o.up[2] = x_i[7] ? {x_i[6:0], 1'b1} : 8'd0;
        // Lower MF: same support, 3/4 height.
        for (int k = 0; k < 3; k++) begin
            mf_o.lo[2'(k)] = mf_o.up[2'(k)] - (mf_o.up[2'(k)] >> 2);
        end
    end

endmodule

// File: rtl/fuzzy_1_core.sv
// Purpose : interval type-2 fuzzy controller, 3x3 rules, Nie-Tan reduction, free-running frames.
// Latency : 5-cycle frame (SAMPLE, ROW0..ROW2, DEFUZ); input change visible on output within 9 cycles.
// Backpressure: none; EN_REGRAS=0 idles in SAMPLE after the current frame, outputs hold.
// Ports   : clk_0 clock, Srst sync active-high reset, bus (slave) carries inputs, enable and outputs.
module fuzzy_1_core
    import fuzzy_1_pkg::*;
(
    input  logic       clk_0,
    input  logic       Srst,
    fuzzy_1_if.slave   bus
);

    state_t             state_q, state_d;
    mf_t                mf1_c, mf2_c;
    mf_t                mf1_q, mf1_d, mf2_q, mf2_d;
    logic [5:0]         fou_q, fou_d;
    logic [W_NUM-1:0]   num_q, num_d;
    logic [W_DEN-1:0]   den_q, den_d;
    logic [W_IN-1:0]    out_q, out_d;

    logic [1:0]         row;
    logic [W_NUM-1:0]   row_num;
    logic [W_DEN-1:0]   row_den;
    logic [W_IN-1:0]    quot;

    fuzzy_1_mf u_mf1 (.x_i(bus.Entrada_01), .mf_o(mf1_c));
    fuzzy_1_mf u_mf2 (.x_i(bus.Entrada_02), .mf_o(mf2_c));

    // One row of the rule base: input-1 set 'row' against all three input-2 sets.
    always_comb begin : rule_row
        logic [W_IN-1:0] up, lo;
        logic [W_W-1:0]  w;
        case (state_q)
            ROW1:    row = 2'd1;
            ROW2:    row = 2'd2;
            default: row = 2'd0;
        endcase
        row_num = '0;
        row_den = '0;
        for (int j = 0; j < 3; j++) begin
            up = min8(mf1_q.up[row], mf2_q.up[2'(j)]);
            lo = min8(mf1_q.lo[row], mf2_q.lo[2'(j)]);
            w  = {1'b0, up} + {1'b0, lo};
            row_den = row_den + W_DEN'(w);
            row_num = row_num + W_NUM'(cons_at(3'(row) + 3'(j))) * W_NUM'(w);
        end
    end

    // Restoring divider, 8 quotient bits only: num <= 240*den keeps the quotient below 256.
    always_comb begin : divider
        logic [W_NUM+7:0] rem, dsh;
        rem  = {8'd0, num_q};
        quot = '0;
        for (int b = 7; b >= 0; b--) begin
            dsh = (W_NUM+8)'(den_q) << b;
            if (rem >= dsh) begin
                rem          = rem - dsh;
                quot[3'(b)]  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        mf1_d   = mf1_q;
        mf2_d   = mf2_q;
        fou_d   = fou_q;
        num_d   = num_q;
        den_d   = den_q;
        out_d   = out_q;
        case (state_q)
            SAMPLE: begin
                if (bus.EN_REGRAS) begin
                    mf1_d   = mf1_c;
                    mf2_d   = mf2_c;
                    fou_d   = {mf2_c.up[2] != '0, mf2_c.up[1] != '0, mf2_c.up[0] != '0,
                               mf1_c.up[2] != '0, mf1_c.up[1] != '0, mf1_c.up[0] != '0};
                    num_d   = '0;
                    den_d   = '0;
                    state_d = ROW0;
                end
            end
            ROW0, ROW1, ROW2: begin
                num_d   = num_q + row_num;
                den_d   = den_q + row_den;
                state_d = (state_q == ROW0) ? ROW1 : (state_q == ROW1) ? ROW2 : DEFUZ;
            end
            DEFUZ: begin
                out_d   = (den_q == '0) ? 8'd128 : quot;
                state_d = SAMPLE;
            end
            default: state_d = SAMPLE;
        endcase
    end

    always_ff @(posedge clk_0) begin
        if (Srst) begin
            state_q <= SAMPLE;
            mf1_q   <= '0;
            mf2_q   <= '0;
            fou_q   <= '0;
            num_q   <= '0;
            den_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            mf1_q   <= mf1_d;
            mf2_q   <= mf2_d;
            fou_q   <= fou_d;
            num_q   <= num_d;
            den_q   <= den_d;
            out_q   <= out_d;
        end
    end

    assign bus.FOU_ATIVO     = fou_q;
    assign bus.saida_defuzzy = out_q;

endmodule

// File: tb/tb_fuzzy_1_core.sv
// Purpose : self-checking bench for fuzzy_1_core with an expected-value scoreboard.
// Latency : checks output within the 9-cycle bound and exact DEFUZ-edge timing.
// Backpressure: exercises EN_REGRAS idle/hold and mid-frame synchronous reset.
module tb_fuzzy_1_core;

    logic clk = 1'b0;
    logic srst;

    always #5 clk = ~clk;

    fuzzy_1_if bus ();

    fuzzy_1_core dut (
        .clk_0 (clk),
        .Srst  (srst),
        .bus   (bus)
    );

    typedef struct {
        int out;
        int fou;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // ---------------- reference model, straight from the MF / rule definitions ----------------
    function automatic int mf_up(input int x, input int k);
        int v;
        v = 0;
        case (k)
            0: v = (x < 128) ? 255 - 2 * x : 0;
            1: begin
                v = (x < 128) ? 2 * x : 2 * (255 - x);
                if (v > 255) v = 255;
            end
            default: v = (x > 127) ? 2 * x - 255 : 0;
        endcase
        return v;
    endfunction

    function automatic int cons(input int k);
        case (k)
            0: return 16;
            1: return 72;
            2: return 128;
            3: return 184;
            default: return 240;
        endcase
    endfunction

    function automatic void model(input int a, input int b, output int o, output int f);
        int num, den, u1, u2, l1, l2, up, lo;
        num = 0; den = 0; f = 0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                u1 = mf_up(a, i); u2 = mf_up(b, j);
                l1 = u1 - u1 / 4; l2 = u2 - u2 / 4;
                up = (u1 < u2) ? u1 : u2;
                lo = (l1 < l2) ? l1 : l2;
                den += up + lo;
                num += cons(i + j) * (up + lo);
            end
        end
        o = (den == 0) ? 128 : num / den;
        for (int k = 0; k < 3; k++) begin
            if (mf_up(a, k) != 0) f |= (1 << k);
            if (mf_up(b, k) != 0) f |= (1 << (k + 3));
        end
    endfunction

    task automatic drive(input int a, input int b, input logic en);
        bus.Entrada_01 = 8'(a);
        bus.Entrada_02 = 8'(b);
        bus.EN_REGRAS  = en;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        exp_t e;
        srst = 1'b1;
        drive(1, 1, 1'b1);          // enabled during reset: reset must dominate
        sb.push_back('{0, 0});
        repeat (4) @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (bus.saida_defuzzy !== 8'(e.out)) begin
            failures++;
            $display("FAIL reset_out: got %0d expected %0d", bus.saida_defuzzy, e.out);
        end
        checks++;
        if (bus.FOU_ATIVO !== 6'(e.fou)) begin
            failures++;
            $display("FAIL reset_fou: got %b expected %b", bus.FOU_ATIVO, 6'(e.fou));
        end
    endtask

    task automatic test_vectors();
        int   va[4], vb[4], vo[4], vf[4];
        exp_t e;
        bit   hit;
        va = '{1, 1, 254, 128};
        vb = '{1, 254, 254, 128};
        vo = '{17, 128, 238, 128};
        vf = '{6'b011011, 6'b110011, 6'b110110, 6'b110110};
        @(negedge clk);
        srst = 1'b0;
        for (int v = 0; v < 4; v++) begin
            drive(va[v], vb[v], 1'b1);
            sb.push_back('{vo[v], vf[v]});
            e   = sb.pop_front();
            hit = 1'b0;
            for (int c = 0; c < 9 && !hit; c++) begin
                @(negedge clk);
                if (bus.saida_defuzzy === 8'(e.out)) hit = 1'b1;
            end
            checks++;
            if (!hit) begin
                failures++;
                $display("FAIL vec%0d_out (%0d,%0d): got %0d expected %0d within 9 cycles",
                         v, va[v], vb[v], bus.saida_defuzzy, e.out);
            end
            checks++;
            if (bus.FOU_ATIVO !== 6'(e.fou)) begin
                failures++;
                $display("FAIL vec%0d_fou: got %b expected %b", v, bus.FOU_ATIVO, 6'(e.fou));
            end
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic test_sweep(input int axis, input int fixed);
        int   o, f, prev;
        exp_t e;
        prev = 0;
        for (int v = 1; v <= 254; v++) begin
            if (axis == 0) begin
                drive(v, fixed, 1'b1);
                model(v, fixed, o, f);
            end else begin
                drive(fixed, v, 1'b1);
                model(fixed, v, o, f);
            end
            sb.push_back('{o, f});
            repeat (14) @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (bus.saida_defuzzy !== 8'(e.out)) begin
                failures++;
                $display("FAIL sweep%0d_out v=%0d: got %0d expected %0d", axis, v, bus.saida_defuzzy, e.out);
            end
            checks++;
            if (bus.FOU_ATIVO !== 6'(e.fou)) begin
                failures++;
                $display("FAIL sweep%0d_fou v=%0d: got %b expected %b", axis, v, bus.FOU_ATIVO, 6'(e.fou));
            end
            checks++;
            if (int'(bus.saida_defuzzy) < prev) begin
                failures++;
                $display("FAIL sweep%0d_mono v=%0d: got %0d expected >= %0d", axis, v, bus.saida_defuzzy, prev);
            end
            prev = int'(bus.saida_defuzzy);
        end
    endtask

    // Entered with inputs (200,254) settled and the FSM running.
    task automatic test_enable();
        int   o_old, f_old, o_new, f_new;
        exp_t e;
        model(200, 254, o_old, f_old);
        model(30, 220, o_new, f_new);
        bus.EN_REGRAS = 1'b0;
        repeat (10) @(negedge clk);          // in-flight frame completes, then idle
        drive(30, 220, 1'b0);
        sb.push_back('{o_old, f_old});
        repeat (20) @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (bus.saida_defuzzy !== 8'(e.out)) begin
            failures++;
            $display("FAIL en_hold_out: got %0d expected %0d", bus.saida_defuzzy, e.out);
        end
        checks++;
        if (bus.FOU_ATIVO !== 6'(e.fou)) begin
            failures++;
            $display("FAIL en_hold_fou: got %b expected %b", bus.FOU_ATIVO, 6'(e.fou));
        end
        // Reassert: the very next edge is SAMPLE; drop enable again mid-frame.
        bus.EN_REGRAS = 1'b1;
        sb.push_back('{o_new, f_new});
        @(negedge clk);
        bus.EN_REGRAS = 1'b0;
        e = sb.pop_front();
        checks++;
        if (bus.FOU_ATIVO !== 6'(e.fou)) begin
            failures++;
            $display("FAIL en_restart_fou: got %b expected %b", bus.FOU_ATIVO, 6'(e.fou));
        end
        repeat (3) @(negedge clk);           // after ROW2 edge: output not yet updated
        checks++;
        if (bus.saida_defuzzy !== 8'(o_old)) begin
            failures++;
            $display("FAIL en_early_out: got %0d expected %0d", bus.saida_defuzzy, o_old);
        end
        @(negedge clk);                      // after DEFUZ edge
        checks++;
        if (bus.saida_defuzzy !== 8'(e.out)) begin
            failures++;
            $display("FAIL en_defuz_out: got %0d expected %0d", bus.saida_defuzzy, e.out);
        end
        drive(250, 5, 1'b0);
        repeat (20) @(negedge clk);
        checks++;
        if (bus.saida_defuzzy !== 8'(o_new) || bus.FOU_ATIVO !== 6'(f_new)) begin
            failures++;
            $display("FAIL en_idle_hold: got %0d/%b expected %0d/%b",
                     bus.saida_defuzzy, bus.FOU_ATIVO, o_new, 6'(f_new));
        end
    endtask

    // Entered idle (EN_REGRAS=0) at a negedge.
    task automatic test_reset_mid_frame();
        int   o, f;
        exp_t e;
        bit   hit;
        drive(128, 30, 1'b1);
        @(negedge clk);                      // SAMPLE edge taken
        @(negedge clk);                      // now in ROW1
        srst = 1'b1;
        bus.EN_REGRAS = 1'b0;
        sb.push_back('{0, 0});
        @(negedge clk);
        srst = 1'b0;
        e = sb.pop_front();
        checks++;
        if (bus.saida_defuzzy !== 8'(e.out) || bus.FOU_ATIVO !== 6'(e.fou)) begin
            failures++;
            $display("FAIL rst_mid: got %0d/%b expected %0d/%b",
                     bus.saida_defuzzy, bus.FOU_ATIVO, e.out, 6'(e.fou));
        end
        repeat (12) @(negedge clk);
        checks++;
        if (bus.saida_defuzzy !== 8'd0 || bus.FOU_ATIVO !== 6'd0) begin
            failures++;
            $display("FAIL rst_no_stale: got %0d/%b expected 0/000000", bus.saida_defuzzy, bus.FOU_ATIVO);
        end
        // Recovery after reset.
        model(128, 30, o, f);
        bus.EN_REGRAS = 1'b1;
        sb.push_back('{o, f});
        e   = sb.pop_front();
        hit = 1'b0;
        for (int c = 0; c < 9 && !hit; c++) begin
            @(negedge clk);
            if (bus.saida_defuzzy === 8'(e.out)) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL rst_recover_out: got %0d expected %0d", bus.saida_defuzzy, e.out);
        end
        checks++;
        if (bus.FOU_ATIVO !== 6'(e.fou)) begin
            failures++;
            $display("FAIL rst_recover_fou: got %b expected %b", bus.FOU_ATIVO, 6'(e.fou));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        srst = 1'b1;
        drive(0, 0, 1'b0);
        @(negedge clk);
        test_reset();
        test_vectors();
        test_sweep(0, 60);
        test_sweep(1, 200);
        test_enable();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
